// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : funct3 encodings, FSM states and access-size helper for dmem_unit
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Bytes touched by a load/store of the given funct3.
    function automatic logic [3:0] access_size(input logic [2:0] funct3);
        logic [3:0] n;
        case (funct3)
            F3_B, F3_BU: n = 4'd1;
            F3_H, F3_HU: n = 4'd2;
            F3_W, F3_WU: n = 4'd4;
            default:     n = 4'd8;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_ext.sv
`default_nettype none
// ============================================================================
// dmem_load_ext : sign/zero extension of raw little-endian load bytes
// Revision      : 1.0
// ============================================================================
module dmem_load_ext
    import dmem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] raw_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        data_o = '0;
        case (funct3_i)
            F3_B:    data_o = {{(XLEN-8){raw_i[7]}},   raw_i[7:0]};
            F3_H:    data_o = {{(XLEN-16){raw_i[15]}}, raw_i[15:0]};
            F3_W:    data_o = {{(XLEN-32){raw_i[31]}}, raw_i[31:0]};
            F3_D:    data_o = raw_i;
            F3_BU:   data_o = {{(XLEN-8){1'b0}},  raw_i[7:0]};
            F3_HU:   data_o = {{(XLEN-16){1'b0}}, raw_i[15:0]};
            F3_WU:   data_o = {{(XLEN-32){1'b0}}, raw_i[31:0]};
            default: data_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_unit.sv
`default_nettype none
// ============================================================================
// dmem_unit : byte-addressed RV64 data memory, valid/ready port, READ_LAT
//             cycles per access. Define DMEM_MISALIGN_TRAP_EN to trap
//             misaligned accesses instead of performing them bytewise.
// Revision  : 1.0
// ============================================================================
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 512,
    parameter int ADDR_W      = 10,
    parameter int XLEN        = 64,
    parameter int READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_BYTES);
    localparam int         NB       = XLEN / 8;
    localparam logic [2:0] LAST_CNT = 3'(READ_LAT - 1);

    state_e              state_q, state_d;
    logic [2:0]          cnt_q;
    logic                we_q;
    logic [2:0]          funct3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [XLEN-1:0]     rdata_q;
    logic                err_q;
    logic [7:0]          mem_q [DEPTH_BYTES];

    logic [IDX_W-1:0]    w_base;
    logic [IDX_W-1:0]    w_lane [NB];
    logic [XLEN-1:0]     w_raw;
    logic [XLEN-1:0]     w_ext;
    logic [3:0]          w_size;
    logic                w_illegal;
    logic                w_misalign;
    logic                w_err;
    logic                w_last;
    logic                w_commit;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid)  state_d = ACCESS;
            ACCESS:  if (w_last)     state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs decoded from state only
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 3'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= 3'd0;
            if (req_valid) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
        end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

    assign w_size    = access_size(funct3_q);
    assign w_illegal = we_q ? funct3_q[2] : (funct3_q == 3'b111);
`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = (addr_q[2:0] & 3'(w_size - 4'd1)) != 3'd0;
`else
    assign w_misalign = 1'b0;
`endif
    assign w_err    = w_illegal | w_misalign;
    assign w_last   = (state_q == ACCESS) && (cnt_q == LAST_CNT);
    // Reset on the commit edge suppresses the write.
    assign w_commit = (state_q == ACCESS) && (cnt_q == 3'd0) && we_q && !w_err && !rst;
    assign w_base   = IDX_W'(addr_q);

    // Power-of-two depth makes the lane adder wrap for free.
    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign w_lane[i]        = w_base + IDX_W'(i);
        assign w_raw[8*i +: 8]  = mem_q[w_lane[i]];
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < NB; i++) begin
                if (4'(i) < w_size) begin
                    mem_q[w_lane[i]] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    dmem_load_ext #(
        .XLEN     (XLEN)
    ) u_load_ext (
        .raw_i    (w_raw),
        .funct3_i (funct3_q),
        .data_o   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (w_last) begin
            err_q   <= w_err;
            rdata_q <= (we_q || w_err) ? '0 : w_ext;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_unit.sv
`default_nettype none
// ============================================================================
// tb_dmem_unit : directed bench for dmem_unit at READ_LAT 1 and 3, checked
//                against a byte-array reference model.
// Revision     : 1.0
// ============================================================================
module tb_dmem_unit;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic [9:0]  req_addr   [2];
    logic [63:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [63:0] resp_rdata [2];
    logic        resp_err   [2];

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mm [2][512];
    logic [63:0] exp_rd      [2];
    logic        exp_err     [2];
    logic        exp_pending [2];

    always #5 clk = ~clk;

    dmem_unit #(.DEPTH_BYTES(512), .ADDR_W(10), .XLEN(64), .READ_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_unit #(.DEPTH_BYTES(512), .ADDR_W(10), .XLEN(64), .READ_LAT(3)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RISC-V load/store semantics on a plain byte array.
    function automatic void model_req(input int d, input bit we, input bit [2:0] f3,
                                      input int addr, input logic [63:0] wd,
                                      output logic [63:0] rd, output logic err);
        int          n;
        bit          ill;
        bit          mis;
        logic [63:0] v;
        n   = 1 << f3[1:0];
        ill = we ? f3[2] : (f3 == 3'b111);
        mis = (addr % n) != 0;
        err = ill || (TRAP && mis);
        rd  = '0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < n; i++) mm[d][(addr + i) % 512] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (64'(mm[d][(addr + i) % 512]) << (8*i));
            if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
            rd = v;
        end
    endfunction

    // Every cycle a response is presented it must match the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst[d] && resp_valid[d]) begin
                chk("resp_expected", {63'd0, exp_pending[d]}, 64'd1);
                chk("resp_rdata", resp_rdata[d], exp_rd[d]);
                chk("resp_err", {63'd0, resp_err[d]}, {63'd0, exp_err[d]});
                chk("ready_in_resp", {63'd0, req_ready[d]}, 64'd0);
            end
        end
    end

    task automatic do_req(input int d, input bit we, input bit [2:0] f3, input int addr,
                          input logic [63:0] wd, input int hold,
                          input logic [63:0] lit_rd, input bit lit_err);
        logic [63:0] mrd;
        logic        merr;
        int          w;
        int          lat;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = 10'(addr);
        req_wdata[d]  = wd;
        w = 0;
        while (!req_ready[d] && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", 64'(w), 64'd0);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        model_req(d, we, f3, addr, wd, mrd, merr);
        exp_rd[d]      = mrd;
        exp_err[d]     = merr;
        exp_pending[d] = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!resp_valid[d] && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", 64'(lat), 64'(lat_of(d)));
        chk("lit_rdata", resp_rdata[d], lit_rd);
        chk("lit_err", {63'd0, resp_err[d]}, {63'd0, lit_err});
        if (hold > 0) begin
            // Competing request that must wait for the response to drain.
            req_valid[d]  = 1'b1;
            req_we[d]     = 1'b0;
            req_funct3[d] = 3'b100;
            req_addr[d]   = 10'h020;
        end
        for (int i = 0; i < hold; i++) begin
            chk("bp_ready_low", {63'd0, req_ready[d]}, 64'd0);
            chk("bp_valid_high", {63'd0, resp_valid[d]}, 64'd1);
            @(negedge clk);
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[d]  = 1'b0;
        exp_pending[d] = 1'b0;
    endtask

    task automatic chk_idle(input int d);
        chk("rst_ready", {63'd0, req_ready[d]}, 64'd1);
        chk("rst_valid", {63'd0, resp_valid[d]}, 64'd0);
        chk("rst_rdata", resp_rdata[d], 64'd0);
        chk("rst_err", {63'd0, resp_err[d]}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
            req_addr[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b0;
            exp_rd[d] = '0; exp_err[d] = 1'b0; exp_pending[d] = 1'b0;
            for (int a = 0; a < 512; a++) mm[d][a] = 8'h00;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        chk_idle(0);
        chk_idle(1);

        // READ_LAT = 1
        do_req(0, 1, 3'b011, 'h10, 64'h8877665544332211, 0, 64'h0, 0);
        do_req(0, 0, 3'b011, 'h10, 64'h0, 0, 64'h8877665544332211, 0);
        do_req(0, 0, 3'b100, 'h17, 64'h0, 0, 64'h88, 0);
        do_req(0, 0, 3'b000, 'h17, 64'h0, 0, 64'hFFFFFFFFFFFFFF88, 0);
        do_req(0, 0, 3'b011, 'h10, 64'h0, 5, 64'h8877665544332211, 0);
        do_req(0, 0, 3'b101, 'h16, 64'h0, 0, 64'h8877, 0);

        // wrap across the top of the array
        do_req(0, 1, 3'b000, 511, 64'h11, 0, 64'h0, 0);
        do_req(0, 1, 3'b000, 0,   64'h22, 0, 64'h0, 0);
        do_req(0, 1, 3'b001, 511, 64'hBEEF, 0, 64'h0, TRAP);
        do_req(0, 0, 3'b100, 511, 64'h0, 0, TRAP ? 64'h11 : 64'hEF, 0);
        do_req(0, 0, 3'b100, 0,   64'h0, 0, TRAP ? 64'h22 : 64'hBE, 0);
        do_req(0, 0, 3'b101, 511, 64'h0, 0, TRAP ? 64'h0 : 64'hBEEF, TRAP);

        // illegal funct3
        do_req(0, 1, 3'b100, 'h10, 64'hFFFFFFFFFFFFFFFF, 0, 64'h0, 1);
        do_req(0, 0, 3'b011, 'h10, 64'h0, 0, 64'h8877665544332211, 0);
        do_req(0, 0, 3'b111, 'h10, 64'h0, 0, 64'h0, 1);

        // reset coinciding with the store commit edge
        do_req(0, 1, 3'b000, 'h30, 64'hC3, 0, 64'h0, 0);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b000;
        req_addr[0] = 10'h030; req_wdata[0] = 64'h5A;
        chk("race_accept", {63'd0, req_ready[0]}, 64'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        chk_idle(0);
        do_req(0, 0, 3'b100, 'h30, 64'h0, 0, 64'hC3, 0);

        // READ_LAT = 3
        do_req(1, 1, 3'b010, 'h20, 64'h80000001, 0, 64'h0, 0);
        do_req(1, 0, 3'b010, 'h20, 64'h0, 0, 64'hFFFFFFFF80000001, 0);
        do_req(1, 0, 3'b110, 'h20, 64'h0, 0, 64'h0000000080000001, 0);
        do_req(1, 0, 3'b101, 'h22, 64'h0, 0, 64'h8000, 0);
        do_req(1, 0, 3'b001, 'h22, 64'h0, 4, 64'hFFFFFFFFFFFF8000, 0);
        do_req(1, 1, 3'b011, 'h40, 64'h0123456789ABCDEF, 0, 64'h0, 0);
        do_req(1, 0, 3'b000, 'h40, 64'h0, 0, 64'hFFFFFFFFFFFFFFEF, 0);
        do_req(1, 0, 3'b100, 'h47, 64'h0, 0, 64'h01, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
